// File: rtl/synapse_scheduler_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// synapse_scheduler_if : tick/mask request and slot-sequencing bus. Rev 1.0
// ---------------------------------------------------------------------------
interface synapse_scheduler_if #(
  parameter int N_SLOTS = 128,
  parameter int IDX_W   = 7
);
  logic               tick;
  logic [N_SLOTS-1:0] pre_mask;
  logic [N_SLOTS-1:0] post_mask;
  logic [IDX_W-1:0]   slot_index;
  logic               rd_en;
  logic               wr_en;
  logic               init;
  logic               spike_out;
  logic               post_spike_out;
  logic               last_slot;
  logic               busy;
  logic               done;
  logic [31:0]        pass_count;
  logic [7:0]         overrun_cnt;

  modport master (
    output tick, pre_mask, post_mask,
    input  slot_index, rd_en, wr_en, init, spike_out, post_spike_out,
           last_slot, busy, done, pass_count, overrun_cnt
  );

  modport slave (
    input  tick, pre_mask, post_mask,
    output slot_index, rd_en, wr_en, init, spike_out, post_spike_out,
           last_slot, busy, done, pass_count, overrun_cnt
  );
endinterface
`default_nettype wire

// File: rtl/synapse_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// synapse_scheduler : sequences INIT sweep and READ/WRITE passes over slots.
// Rev 1.0
// ---------------------------------------------------------------------------
module synapse_scheduler #(
  parameter int N_SLOTS = 128,
  parameter int IDX_W   = 7
) (
  input  wire logic           clk,
  input  wire logic           reset,
  synapse_scheduler_if.slave  bus
);

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [IDX_W-1:0] c_LAST = IDX_W'(N_SLOTS - 1);

  logic [2:0]         r_state;
  logic [IDX_W-1:0]   r_slot;
  logic [N_SLOTS-1:0] r_pre;
  logic [N_SLOTS-1:0] r_post;
  logic               r_rd;
  logic               r_wr;
  logic               r_init;
  logic               r_spike;
  logic               r_post_spike;
  logic               r_last;
  logic               r_busy;
  logic               r_done;
  logic [31:0]        r_pass;
  logic [7:0]         r_ovr;

  logic [IDX_W-1:0]   w_slot_inc;
  logic               w_reject;

  assign w_slot_inc = r_slot + IDX_W'(1);
  assign w_reject   = bus.tick && (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_INIT;
      r_slot       <= '0;
      r_pre        <= '0;
      r_post       <= '0;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_init       <= 1'b0;
      r_spike      <= 1'b0;
      r_post_spike <= 1'b0;
      r_last       <= 1'b0;
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
      r_pass       <= '0;
      r_ovr        <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_reject && (r_ovr != 8'hFF)) begin
        r_ovr <= r_ovr + 8'd1;
      end
      case (r_state)
        S_INIT: begin
          // init=0 inside INIT only happens on the first cycle out of reset:
          // present slot 0 before starting to advance.
          if (!r_init) begin
            r_init <= 1'b1;
            r_wr   <= 1'b1;
            r_last <= (r_slot == c_LAST);
          end else if (r_slot == c_LAST) begin
            r_state <= S_IDLE;
            r_slot  <= '0;
            r_init  <= 1'b0;
            r_wr    <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_slot <= w_slot_inc;
            r_last <= (w_slot_inc == c_LAST);
          end
        end
        S_IDLE: begin
          if (bus.tick) begin
            r_pre        <= bus.pre_mask;
            r_post       <= bus.post_mask;
            r_state      <= S_READ;
            r_rd         <= 1'b1;
            r_busy       <= 1'b1;
            r_spike      <= bus.pre_mask[0];
            r_post_spike <= bus.post_mask[0];
            r_last       <= (r_slot == c_LAST);
          end
        end
        S_READ: begin
          r_state <= S_WRITE;
          r_rd    <= 1'b0;
          r_wr    <= 1'b1;
        end
        S_WRITE: begin
          if (r_slot != c_LAST) begin
            r_state      <= S_READ;
            r_slot       <= w_slot_inc;
            r_rd         <= 1'b1;
            r_wr         <= 1'b0;
            r_spike      <= r_pre[w_slot_inc];
            r_post_spike <= r_post[w_slot_inc];
            r_last       <= (w_slot_inc == c_LAST);
          end else begin
            r_state      <= S_DONE;
            r_slot       <= '0;
            r_wr         <= 1'b0;
            r_spike      <= 1'b0;
            r_post_spike <= 1'b0;
            r_last       <= 1'b0;
            r_done       <= 1'b1;
            r_pass       <= r_pass + 32'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state      <= S_INIT;
          r_slot       <= '0;
          r_rd         <= 1'b0;
          r_wr         <= 1'b0;
          r_init       <= 1'b0;
          r_spike      <= 1'b0;
          r_post_spike <= 1'b0;
          r_last       <= 1'b0;
          r_busy       <= 1'b1;
        end
      endcase
    end
  end

  assign bus.slot_index     = r_slot;
  assign bus.rd_en          = r_rd;
  assign bus.wr_en          = r_wr;
  assign bus.init           = r_init;
  assign bus.spike_out      = r_spike;
  assign bus.post_spike_out = r_post_spike;
  assign bus.last_slot      = r_last;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.pass_count     = r_pass;
  assign bus.overrun_cnt    = r_ovr;

endmodule
`default_nettype wire

// File: doc/synapse_scheduler.md
SYNAPSE_SCHEDULER -- requirements
Module: synapse_scheduler

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter N_SLOTS, default 128: number of time-multiplexed synapse slots.
REQ-003 Parameter IDX_W, default 7: slot index width; it SHALL equal ceil(log2(N_SLOTS)).
REQ-004 Port clk, input, 1: rising-edge clock for all state.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port tick, input, 1: one-cycle request to start one population pass.
REQ-007 Port pre_mask, input, N_SLOTS: presynaptic spike per slot, sampled on accepted tick.
REQ-008 Port post_mask, input, N_SLOTS: postsynaptic spike per slot, sampled on accepted tick.
REQ-009 Port slot_index, output, IDX_W: RAM address of the slot being processed.
REQ-010 Port rd_en, output, 1: read phase of the current slot.
REQ-011 Port wr_en, output, 1: write-back phase of the current slot.
REQ-012 Port init, output, 1: initialisation sweep active; datapath writes initial values.
REQ-013 Port spike_out, output, 1: latched pre_mask bit of the current slot.
REQ-014 Port post_spike_out, output, 1: latched post_mask bit of the current slot.
REQ-015 Port last_slot, output, 1: current slot is N_SLOTS-1.
REQ-016 Port busy, output, 1: high in any state other than IDLE.
REQ-017 Port done, output, 1: one-cycle pulse at the end of a pass.
REQ-018 Port pass_count, output, 32: completed passes; wraps modulo 2^32.
REQ-019 Port overrun_cnt, output, 8: rejected ticks; saturates at 255.

Function
REQ-020 The FSM SHALL have five states: INIT, IDLE, READ, WRITE, DONE; all outputs SHALL be registered.
REQ-021 INIT SHALL take one slot per cycle, with wr_en=1 and init=1 and rd_en=0, for slots 0..N_SLOTS-1 in order.
REQ-022 After INIT writes slot N_SLOTS-1, the FSM SHALL go to IDLE with init=0 and slot_index=0.
REQ-023 In IDLE, a tick SHALL be accepted: pre_mask and post_mask are latched, and the next cycle is READ for slot 0.
REQ-024 READ SHALL last exactly one cycle with rd_en=1 and wr_en=0, then go to WRITE for the same slot.
REQ-025 WRITE SHALL last exactly one cycle with wr_en=1 and rd_en=0.
REQ-026 From WRITE, if slot_index is less than N_SLOTS-1, the FSM SHALL increment slot_index and go to READ.
REQ-027 From WRITE of slot N_SLOTS-1, the FSM SHALL go to DONE.
REQ-028 DONE SHALL last one cycle with done=1, increment pass_count, set slot_index=0, then go to IDLE.
REQ-029 A pass SHALL take 2*N_SLOTS+1 cycles from the cycle after an accepted tick through DONE.
REQ-030 spike_out and post_spike_out SHALL equal the latched mask bits [slot_index] during READ and WRITE, and SHALL be 0 otherwise.
REQ-031 A tick in INIT, READ, WRITE or DONE SHALL be ignored and SHALL increment overrun_cnt, which saturates at 255.
REQ-032 Latched masks SHALL NOT change mid-pass, whatever pre_mask or post_mask do.
REQ-033 last_slot SHALL be 1 exactly when slot_index is N_SLOTS-1 and the state is INIT, READ or WRITE.
REQ-034 slot_index SHALL never exceed N_SLOTS-1; it returns to 0 after DONE and after INIT completes.
REQ-035 rd_en and wr_en SHALL never be 1 in the same cycle.

Reset
REQ-036 While reset=1, the following SHALL all be 0: slot_index, rd_en, wr_en, init, spike_out, post_spike_out, last_slot, done, pass_count, overrun_cnt, and both latched masks.
REQ-037 busy SHALL be 1 while reset=1, and the FSM SHALL be held in INIT at slot 0.
REQ-038 The first cycle after reset deasserts SHALL be INIT slot 0, with init=1 and wr_en=1.
REQ-039 Reset asserted mid-pass or mid-INIT SHALL abandon the operation with no done pulse, and SHALL restart INIT from slot 0.

Verification
REQ-040 Scenario 1, reset release with N_SLOTS=128 -> init=wr_en=1 for 128 consecutive cycles with slot_index 0..127; then busy=0, slot_index=0.
REQ-041 Scenario 2, tick in IDLE with pre_mask bit 5 set only -> rd_en then wr_en alternate for 256 cycles; spike_out=1 only in slot 5's READ and WRITE cycles; done=1 on cycle 257 after tick; pass_count=1.
REQ-042 Scenario 3, pre_mask changed to all ones mid-pass -> spike_out still reflects the latched mask; the next pass uses the new mask.
REQ-043 Scenario 4, ticks at cycles 10 and 100 after an accepted tick, plus one during INIT -> overrun_cnt=3, pass_count unaffected; 300 rejected ticks over several passes -> overrun_cnt=255.
REQ-044 Scenario 5, reset asserted during WRITE of slot 40 -> no done pulse; INIT restarts at slot 0; counters read 0.
REQ-045 Scenario 6, three back-to-back passes with tick in the first IDLE cycle each time -> pass_count=3; IDLE lasts 1 cycle between passes; the protocol assertion rd_en&wr_en==0 holds throughout.
